// File: rtl/arm_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : arm_multicycle_ctrl
// Purpose  : Multicycle ARM-subset control unit: FSM sequencing, datapath
//            selects, NZCV flags register and condition-gated writes.
// Revision : 1.0 - initial release
// ============================================================================
module arm_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] RegSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUControl,
    output logic [3:0] Flags
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXECR  = 4'd2,
        EXECI  = 4'd3,
        ALUWB  = 4'd4,
        MEMADR = 4'd5,
        MEMRD  = 4'd6,
        MEMWB  = 4'd7,
        MEMWR  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       condex_q, condex_d;

    logic [1:0] w_alu_dec;
    logic       w_cmd_valid;
    logic       w_exec;
    logic       w_rd_pc;

    function automatic logic f_condex(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            4'b0000: f_condex = z;
            4'b0001: f_condex = !z;
            4'b0010: f_condex = c;
            4'b0011: f_condex = !c;
            4'b0100: f_condex = n;
            4'b0101: f_condex = !n;
            4'b0110: f_condex = v;
            4'b0111: f_condex = !v;
            4'b1000: f_condex = c && !z;
            4'b1001: f_condex = !c || z;
            4'b1010: f_condex = (n == v);
            4'b1011: f_condex = (n != v);
            4'b1100: f_condex = !z && (n == v);
            4'b1101: f_condex = z || (n != v);
            4'b1110: f_condex = 1'b1;
            default: f_condex = 1'b0;
        endcase
    endfunction

    always_comb begin
        w_alu_dec   = 2'b00;
        w_cmd_valid = 1'b1;
        case (Funct[4:1])
            4'b0100: w_alu_dec = 2'b00;
            4'b0010: w_alu_dec = 2'b01;
            4'b0000: w_alu_dec = 2'b10;
            4'b1100: w_alu_dec = 2'b11;
            default: w_cmd_valid = 1'b0;
        endcase
    end

    assign w_exec  = (state_q == EXECR) || (state_q == EXECI);
    assign w_rd_pc = (Rd == 4'd15);

    always_comb begin
        state_d  = FETCH;
        condex_d = condex_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                condex_d = f_condex(Cond, flags_q);
                case (Op)
                    2'b00:   state_d = Funct[5] ? EXECI : EXECR;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            EXECR, EXECI: state_d = ALUWB;
            MEMADR: state_d = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_d = MEMWB;
            default: state_d = FETCH;
        endcase
    end

    // Logical ops (AND/ORR) leave C and V untouched.
    always_comb begin
        flags_d = flags_q;
        if (w_exec && condex_q && Funct[0] && w_cmd_valid) begin
            flags_d[3:2] = ALUFlags[3:2];
            if (!w_alu_dec[1]) begin
                flags_d[1:0] = ALUFlags[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        ImmSrc     = Op;
        RegSrc     = {Op == 2'b01, Op == 2'b10};
        case (state_q)
            FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            EXECR: ALUControl = w_alu_dec;
            EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_alu_dec;
            end
            ALUWB: begin
                RegWrite = condex_q && w_cmd_valid && !w_rd_pc;
                PCWrite  = condex_q && w_cmd_valid && w_rd_pc;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = condex_q && !w_rd_pc;
                PCWrite   = condex_q && w_rd_pc;
            end
            MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = condex_q;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = condex_q;
            end
            default: ;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            IRWrite  = 1'b0;
        end
    end

    assign Flags = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_arm_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_arm_multicycle_ctrl
// Purpose  : Self-checking bench; an instruction-level reference model
//            predicts every cycle's control vector and the NZCV register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arm_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] Cond = 4'd0;
    logic [1:0] Op = 2'd0;
    logic [5:0] Funct = 6'd0;
    logic [3:0] Rd = 4'd0;
    logic [3:0] ALUFlags = 4'd0;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
    logic [3:0] Flags;

    int vectors = 0;
    int miscompares = 0;
    logic [3:0]  m_flags = 4'd0;
    logic [19:0] exp_q[$];
    logic [19:0] w_obs;

    arm_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Flags(Flags)
    );

    always #5 clk = ~clk;

    assign w_obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
                    ALUSrcB, ResultSrc, ImmSrc, ALUControl, Flags};

    function automatic logic [19:0] mk(input logic pc, input logic mw, input logic rw,
                                       input logic irw, input logic adr, input logic [1:0] op,
                                       input logic sa, input logic [1:0] sb,
                                       input logic [1:0] res, input logic [1:0] ctl,
                                       input logic [3:0] fl);
        return {pc, mw, rw, irw, adr, (op == 2'b01), (op == 2'b10), sa, sb, res, op, ctl, fl};
    endfunction

    // Odd condition codes are the negation of the preceding even code.
    function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
        logic r;
        case (cond[3:1])
            3'd0: r = f[2];
            3'd1: r = f[1];
            3'd2: r = f[3];
            3'd3: r = f[0];
            3'd4: r = f[1] && !f[2];
            3'd5: r = (f[3] == f[0]);
            3'd6: r = !f[2] && (f[3] == f[0]);
            default: r = 1'b1;
        endcase
        return cond[0] ? !r : r;
    endfunction

    task automatic build(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] fn,
                         input logic [3:0] rd, input logic [3:0] af);
        logic       cp, valid, wr;
        logic [1:0] ctl;
        logic [3:0] fl, nf;
        cp = cond_ok(cond, m_flags);
        fl = m_flags;
        exp_q.delete();
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, op, 1'b1, 2'd2, 2'd2, 2'd0, fl));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op, 1'b1, 2'd2, 2'd2, 2'd0, fl));
        if (op == 2'b00) begin
            valid = 1'b1;
            ctl   = 2'd0;
            case (fn[4:1])
                4'd4:    ctl = 2'd0;
                4'd2:    ctl = 2'd1;
                4'd0:    ctl = 2'd2;
                4'd12:   ctl = 2'd3;
                default: valid = 1'b0;
            endcase
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op, 1'b0, {1'b0, fn[5]}, 2'd0, ctl, fl));
            nf = fl;
            if (cp && fn[0] && valid) begin
                nf[3:2] = af[3:2];
                if (ctl < 2'd2) nf[1:0] = af[1:0];
            end
            wr = cp && valid;
            exp_q.push_back(mk(wr && rd == 4'd15, 1'b0, wr && rd != 4'd15, 1'b0, 1'b0, op,
                               1'b0, 2'd0, 2'd0, 2'd0, nf));
            m_flags = nf;
        end else if (op == 2'b01) begin
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op, 1'b0, 2'd1, 2'd0, 2'd0, fl));
            if (fn[0]) begin
                exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, op, 1'b0, 2'd0, 2'd0, 2'd0, fl));
                exp_q.push_back(mk(cp && rd == 4'd15, 1'b0, cp && rd != 4'd15, 1'b0, 1'b0, op,
                                   1'b0, 2'd0, 2'd1, 2'd0, fl));
            end else begin
                exp_q.push_back(mk(1'b0, cp, 1'b0, 1'b0, 1'b1, op, 1'b0, 2'd0, 2'd0, 2'd0, fl));
            end
        end else if (op == 2'b10) begin
            exp_q.push_back(mk(cp, 1'b0, 1'b0, 1'b0, 1'b0, op, 1'b0, 2'd1, 2'd2, 2'd0, fl));
        end
    endtask

    task automatic set_inputs(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] fn,
                              input logic [3:0] rd, input logic [3:0] af);
        Cond = cond; Op = op; Funct = fn; Rd = rd; ALUFlags = af;
    endtask

    // Entered just after a clock edge that leaves the DUT in FETCH.
    task automatic run_instr(input string name, input logic [3:0] cond, input logic [1:0] op,
                             input logic [5:0] fn, input logic [3:0] rd, input logic [3:0] af);
        build(cond, op, fn, rd, af);
        set_inputs(cond, op, fn, rd, af);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            vectors++;
            if (w_obs !== exp_q[k]) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got %05h expected %05h", name, k, w_obs, exp_q[k]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        Op    = 2'b00;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++;
            if ({PCWrite, MemWrite, RegWrite, IRWrite, Flags} !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_hold cycle %0d: got %02h expected 00", k,
                         {PCWrite, MemWrite, RegWrite, IRWrite, Flags});
            end
            @(posedge clk);
            #1;
        end
        reset   = 1'b0;
        m_flags = 4'd0;
    endtask

    task automatic test_dp_and_branch;
        run_instr("add_imm", 4'he, 2'b00, 6'b101000, 4'd3, 4'($urandom));
        run_instr("subs", 4'he, 2'b00, 6'b000101, 4'd4, 4'b0100);
        run_instr("beq_taken", 4'h0, 2'b10, 6'($urandom), 4'($urandom), 4'($urandom));
        run_instr("bne_not_taken", 4'h1, 2'b10, 6'($urandom), 4'($urandom), 4'($urandom));
        run_instr("add_pc_dest", 4'he, 2'b00, 6'b001000, 4'd15, 4'($urandom));
        run_instr("never_cond", 4'hf, 2'b00, 6'b011001, 4'd5, 4'b1111);
        run_instr("nop_op11", 4'he, 2'b11, 6'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic test_mem;
        run_instr("ldr", 4'he, 2'b01, 6'b011001, 4'd2, 4'($urandom));
        run_instr("str", 4'he, 2'b01, 6'b011000, 4'd6, 4'($urandom));
        run_instr("ldr_pc", 4'he, 2'b01, 6'b011001, 4'd15, 4'($urandom));
    endtask

    task automatic test_flags;
        run_instr("adds_0011", 4'he, 2'b00, 6'b001001, 4'd1, 4'b0011);
        run_instr("ands_keep_cv", 4'he, 2'b00, 6'b000001, 4'd1, 4'b1000);
        run_instr("orrs", 4'he, 2'b00, 6'b111001, 4'd1, 4'b0110);
        run_instr("bad_cmd_s", 4'he, 2'b00, 6'b011111, 4'd7, 4'b0101);
        run_instr("subs_failcond", 4'h0, 2'b00, 6'b000101, 4'd7, 4'b0101);
    endtask

    task automatic test_reset_mid;
        run_instr("adds_1111", 4'he, 2'b00, 6'b001001, 4'd1, 4'b1111);
        build(4'he, 2'b01, 6'b011000, 4'd3, 4'd0);
        set_inputs(4'he, 2'b01, 6'b011000, 4'd3, 4'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++;
            if (w_obs !== exp_q[k]) begin
                miscompares++;
                $display("FAIL str_pre_abort cycle %0d: got %05h expected %05h", k, w_obs, exp_q[k]);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++;
            if ({PCWrite, MemWrite, RegWrite, IRWrite} !== 4'b0000) begin
                miscompares++;
                $display("FAIL abort_enables cycle %0d: got %01h expected 0", k,
                         {PCWrite, MemWrite, RegWrite, IRWrite});
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        if (Flags !== 4'b0000) begin
            miscompares++;
            $display("FAIL abort_flags: got %01h expected 0", Flags);
        end
        reset   = 1'b0;
        m_flags = 4'd0;
        run_instr("post_abort_b", 4'he, 2'b10, 6'd0, 4'd0, 4'd0);
    endtask

    task automatic test_back_to_back;
        logic [1:0] op;
        logic [5:0] fn;
        for (int i = 0; i < 150; i++) begin
            op = 2'($urandom);
            fn = 6'($urandom);
            if (op == 2'b00 && $urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 3))
                    0:       fn[4:1] = 4'b0100;
                    1:       fn[4:1] = 4'b0010;
                    2:       fn[4:1] = 4'b0000;
                    default: fn[4:1] = 4'b1100;
                endcase
            end
            run_instr("random", 4'($urandom), op, fn, 4'($urandom), 4'($urandom));
        end
    endtask

    initial begin
        test_reset;
        test_dp_and_branch;
        test_mem;
        test_flags;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arm_multicycle_ctrl.md
Name: arm_multicycle_ctrl

Overview:
Control unit for the 32-bit multicycle ARM-subset CPU. It sequences one shared ALU, memory port and register file across FETCH/DECODE/EXECUTE/writeback states. It drives the immediate extender's ImmSrc and all datapath mux selects and write enables. It holds the NZCV flags register and gates architectural writes on the instruction condition field.

Parameters:
None. Instruction subset and encodings are fixed; no parameters are required.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
Cond  in  4  Instr[31:28]
Op  in  2  Instr[27:26]: 00 DP, 01 LDR/STR, 10 B, 11 unsupported
Funct  in  6  Instr[25:20]: DP = {I, cmd[3:0], S}; mem: bit0 = L (1 = LDR)
Rd  in  4  Instr[15:12]
ALUFlags  in  4  {N,Z,C,V} from the ALU, same cycle
PCWrite  out  1  PC register enable
MemWrite  out  1  data memory write enable
RegWrite  out  1  register file write enable
IRWrite  out  1  instruction register enable
AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address
RegSrc  out  2  [0] = 1 reads R15 for branch; [1] = 1 reads Rd as src2 for STR
ALUSrcA  out  1  0 = RD1, 1 = PC
ALUSrcB  out  2  00 = RD2, 01 = ExtImm, 10 = constant 4
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ImmSrc  out  2  extender select (00 imm8, 01 imm12, 10 branch imm24)
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
Flags  out  4  current NZCV register (debug/visibility)

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- On reset:
  - state = FETCH; Flags = 0; CondExReg = 0.
  - While reset = 1, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. The first FETCH cycle occurs on the first edge after reset drops.
  - Reset asserted mid-instruction aborts the instruction; no write enable pulses afterwards.
- Moore FSM. Outputs not listed for a state are 0.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, PCWrite=1 → DECODE.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Latches CondExReg = CondEx(Cond, Flags). Next state:
    - Op=00, I=0 → EXECR
    - Op=00, I=1 → EXECI
    - Op=01 → MEMADR
    - Op=10 → BRANCH
    - Op=11 → FETCH (NOP)
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALU decode active → ALUWB.
  - EXECI: ALUSrcA=0, ALUSrcB=01, ALU decode active → ALUWB.
  - ALUWB: ResultSrc=00.
    - Rd≠15: RegWrite = CondExReg & cmdValid.
    - Rd=15: PCWrite = CondExReg & cmdValid; RegWrite = 0.
    - → FETCH.
  - MEMADR: ALUSrcA=0, ALUSrcB=01. L=1 → MEMRD, L=0 → MEMWR.
  - MEMRD: AdrSrc=1, ResultSrc=00 → MEMWB.
  - MEMWB: ResultSrc=01. RegWrite (or PCWrite if Rd=15) = CondExReg → FETCH.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemWrite = CondExReg → FETCH.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite = CondExReg → FETCH.
- Latency in cycles: B = 3, DP = 4, STR = 4, LDR = 5, Op=11 = 2.
- Combinational outputs:
  - ImmSrc = Op in every state.
  - RegSrc = {Op==01, Op==10} in every state.
- ALU decode, active in EXECR/EXECI only; elsewhere ALUControl = 00:
  - cmd 0100 → 00; 0010 → 01; 0000 → 10; 1100 → 11.
  - Any other cmd: cmdValid = 0, ALUControl = 00, no writes, no flag update.
- Flags update at the end of EXECR/EXECI, only when CondExReg = 1 and S = 1 and cmdValid:
  - N,Z ← ALUFlags[3:2] always.
  - C,V ← ALUFlags[1:0] only for ADD/SUB; AND/ORR keep the previous C,V.
- CondEx for Cond 0000–1110 follows ARM semantics: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL. Cond 1111 = never.
- The flag update at the end of EXECR/EXECI does not affect that instruction's own writeback, because CondExReg was latched in DECODE.

Test Plan:
- Reset for 2 cycles with Op=00 → all enables 0 during reset. First post-reset cycle: IRWrite=1 and PCWrite=1, then DECODE.
- ADD imm: Cond=1110, Op=00, Funct=101000, Rd=3 → states FETCH, DECODE, EXECI, ALUWB. ImmSrc=00, ALUSrcB=01 and ALUControl=00 in EXECI; RegWrite=1 only in ALUWB; Flags unchanged.
- SUBS: Funct=000101, ALUFlags=0100 → Flags=0100 after EXECR. Then BEQ (Cond=0000, Op=10) → PCWrite=1 in BRANCH, ImmSrc=10. BNE (Cond=0001) → PCWrite=0 in BRANCH, 3 cycles total.
- LDR: Op=01, Funct=011001, Rd=2 → 5 cycles, ImmSrc=01, AdrSrc=1 in MEMRD, RegWrite=1 with ResultSrc=01 in MEMWB. STR (Funct=011000) → 4 cycles, RegSrc=10, MemWrite=1 in MEMWR only.
- ANDS with prior Flags=0011, ALUFlags=1000 → Flags=1011 (C,V kept). Unsupported cmd 1111 with S=1 → no RegWrite, Flags unchanged.
- Reset asserted during MEMADR of an STR → MemWrite never asserts; state returns to FETCH; Flags = 0.
